id_stage_hz: RTL

Parametrised decode stage for the 5-stage MIPS pipeline. It holds the register file, decodes IR into DX-stage controls and operands, and registers them into the DX pipeline register. Over the 32-bit decode stage it adds width/depth parameters, a hard-wired r0, addi support, load-use hazard stall, branch flush and illegal-instruction bubbling. It sits between the IF/ID register and EXECUTE; write-back arrives from the MW stage.

---
 rtl/id_stage_hz.sv | 269 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/id_stage_hz.sv
// id_stage_hz: decode stage of the 5-stage MIPS pipeline.
//
// Holds the register file, decodes the instruction in ID into DX-stage
// controls and operands, and registers them into the DX pipeline register.
// Adds load-use stall detection, branch-flush squashing and bubbling of
// unsupported instructions.
//
// Optional build macro:
//   BYPASS_EN  defined   -> register reads return the write-back value when
//                           the MW stage writes the register being read
//                           (write-first register file).
//              undefined -> reads see the pre-write value.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   PC, IR            PC+4 and instruction from IF/ID
//   flush             branch/jump taken, squash the instruction in ID
//   MW_RegWrite, MW_MemtoReg, MW_RD, MDR, MW_ALUout   write-back port
//   stall             combinational load-use stall request to IF
//   MemtoReg, RegWrite, MemRead, MemWrite, branch, jump, illegal, ALUctr
//                     registered DX controls
//   A, B, MD, imm, RD, JT, NPC, DX_PC                 registered DX data
module id_stage_hz #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    localparam int RAW = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] PC,
    input  logic [31:0]     IR,
    input  logic            flush,
    input  logic            MW_RegWrite,
    input  logic            MW_MemtoReg,
    input  logic [RAW-1:0]  MW_RD,
    input  logic [XLEN-1:0] MDR,
    input  logic [XLEN-1:0] MW_ALUout,
    output logic            stall,
    output logic            MemtoReg,
    output logic            RegWrite,
    output logic            MemRead,
    output logic            MemWrite,
    output logic            branch,
    output logic            jump,
    output logic            illegal,
    output logic [2:0]      ALUctr,
    output logic [XLEN-1:0] A,
    output logic [XLEN-1:0] B,
    output logic [XLEN-1:0] MD,
    output logic [15:0]     imm,
    output logic [RAW-1:0]  RD,
    output logic [XLEN-1:0] JT,
    output logic [XLEN-1:0] NPC,
    output logic [XLEN-1:0] DX_PC
);

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_BNE   = 6'd5;
    localparam logic [5:0] OP_ADDI  = 6'd8;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;

    localparam logic [5:0] FN_ADD = 6'd32;
    localparam logic [5:0] FN_SUB = 6'd34;
    localparam logic [5:0] FN_AND = 6'd36;
    localparam logic [5:0] FN_OR  = 6'd37;
    localparam logic [5:0] FN_SLT = 6'd42;

    logic [XLEN-1:0] regs [NREG];

    logic [5:0]      op;
    logic [5:0]      funct;
    logic [RAW-1:0]  rs;
    logic [RAW-1:0]  rt;
    logic [RAW-1:0]  rd_field;
    logic [XLEN-1:0] wb_data;
    logic            wb_en;
    logic [XLEN-1:0] rs_val;
    logic [XLEN-1:0] rt_val;
    logic [XLEN-1:0] imm_sext;

    logic            dec_m2r;
    logic            dec_rw;
    logic            dec_mr;
    logic            dec_mw;
    logic            dec_br;
    logic            dec_jp;
    logic [2:0]      dec_alu;
    logic [RAW-1:0]  dec_rd;
    logic [XLEN-1:0] dec_b;
    logic            legal;
    logic            reads_rt;

    logic            hazard;
    logic            bubble;
    logic            illegal_next;

    assign op    = IR[31:26];
    assign funct = IR[5:0];

    // Register fields are 5 bits in the encoding; resize to the index width.
    assign rs       = RAW'(IR[25:21]);
    assign rt       = RAW'(IR[20:16]);
    assign rd_field = RAW'(IR[15:11]);

    assign wb_data  = MW_MemtoReg ? MDR : MW_ALUout;
    assign wb_en    = MW_RegWrite && (MW_RD != '0);
    assign imm_sext = {{(XLEN-16){IR[15]}}, IR[15:0]};

    // Register file read ports. r0 is forced to zero regardless of contents.
    always_comb begin
        rs_val = regs[rs];
`ifdef BYPASS_EN
        if (wb_en && (MW_RD == rs)) begin
            rs_val = wb_data;
        end
`endif
        if (rs == '0) begin
            rs_val = '0;
        end
    end

    always_comb begin
        rt_val = regs[rt];
`ifdef BYPASS_EN
        if (wb_en && (MW_RD == rt)) begin
            rt_val = wb_data;
        end
`endif
        if (rt == '0) begin
            rt_val = '0;
        end
    end

    // Instruction decode. Unlisted controls stay 0; B defaults to rt.
    always_comb begin
        dec_m2r  = 1'b0;
        dec_rw   = 1'b0;
        dec_mr   = 1'b0;
        dec_mw   = 1'b0;
        dec_br   = 1'b0;
        dec_jp   = (op == OP_J);
        dec_alu  = 3'd0;
        dec_rd   = '0;
        dec_b    = rt_val;
        legal    = 1'b1;
        reads_rt = 1'b0;
        case (op)
            OP_RTYPE: begin
                dec_rd   = rd_field;
                dec_rw   = 1'b1;
                reads_rt = 1'b1;
                case (funct)
                    FN_ADD:  dec_alu = 3'd0;
                    FN_SUB:  dec_alu = 3'd1;
                    FN_AND:  dec_alu = 3'd2;
                    FN_OR:   dec_alu = 3'd3;
                    FN_SLT:  dec_alu = 3'd4;
                    default: legal   = 1'b0;
                endcase
            end
            OP_ADDI: begin
                dec_b  = imm_sext;
                dec_rd = rt;
                dec_rw = 1'b1;
            end
            OP_LW: begin
                dec_b   = imm_sext;
                dec_rd  = rt;
                dec_m2r = 1'b1;
                dec_rw  = 1'b1;
                dec_mr  = 1'b1;
            end
            OP_SW: begin
                dec_b    = imm_sext;
                dec_rd   = rt;
                dec_mw   = 1'b1;
                reads_rt = 1'b1;
            end
            OP_BEQ: begin
                dec_br   = 1'b1;
                dec_alu  = 3'd5;
                reads_rt = 1'b1;
            end
            OP_BNE: begin
                dec_br   = 1'b1;
                dec_alu  = 3'd6;
                reads_rt = 1'b1;
            end
            OP_J: begin
                dec_alu = 3'd7;
            end
            default: begin
                legal = 1'b0;
            end
        endcase
    end

    // Load-use hazard against the load currently sitting in DX. The bubble
    // it causes clears MemRead, so the stall self-terminates after one cycle.
    assign hazard = MemRead && (RD != '0) &&
                    ((RD == rs) || (reads_rt && (RD == rt)));
    assign stall  = hazard && !flush;

    // Flush and stall take precedence over the illegal flag: a squashed or
    // stalled instruction never reports itself as illegal.
    assign bubble       = flush || hazard || !legal;
    assign illegal_next = !legal && !flush && !hazard;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
            regs[1]  <= XLEN'(1);
            regs[2]  <= XLEN'(2);
            MemtoReg <= 1'b0;
            RegWrite <= 1'b0;
            MemRead  <= 1'b0;
            MemWrite <= 1'b0;
            branch   <= 1'b0;
            jump     <= 1'b0;
            illegal  <= 1'b0;
            ALUctr   <= 3'd0;
            RD       <= '0;
            A        <= '0;
            B        <= '0;
            MD       <= '0;
            imm      <= '0;
            JT       <= '0;
            NPC      <= '0;
            DX_PC    <= '0;
        end else begin
            if (wb_en) begin
                regs[MW_RD] <= wb_data;
            end
            A     <= rs_val;
            B     <= dec_b;
            MD    <= rt_val;
            imm   <= IR[15:0];
            JT    <= {PC[XLEN-1:28], IR[25:0], 2'b00};
            NPC   <= PC;
            DX_PC <= PC;
            if (bubble) begin
                MemtoReg <= 1'b0;
                RegWrite <= 1'b0;
                MemRead  <= 1'b0;
                MemWrite <= 1'b0;
                branch   <= 1'b0;
                jump     <= 1'b0;
                ALUctr   <= 3'd0;
                RD       <= '0;
            end else begin
                MemtoReg <= dec_m2r;
                RegWrite <= dec_rw;
                MemRead  <= dec_mr;
                MemWrite <= dec_mw;
                branch   <= dec_br;
                jump     <= dec_jp;
                ALUctr   <= dec_alu;
                RD       <= dec_rd;
            end
            illegal <= illegal_next;
        end
    end

endmodule
